// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: program counter, next-PC selection (sequential,
// branch, jump, stall) and the IF/ID pipeline register with a fetch counter.
module etapa_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic [31:0] fetch_count_o
);

    logic [31:0] pc;
    logic [31:0] pc_next;

    assign pc_o        = pc;
    assign imem_addr_o = pc;
    assign pc_plus4_o  = pc + 32'd4;

    // Redirects beat stall: a resolved branch/jump must steer the PC even
    // while ID is holding; the jump region comes from the instruction in ID.
    always_comb begin
        pc_next = pc_plus4_o;
        if (branch_taken_i)
            pc_next = {branch_target_i[31:2], 2'b00};
        else if (jump_i)
            pc_next = {ifid_pc4_o[31:28], jump_index_i, 2'b00};
        else if (stall_i)
            pc_next = pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_instr_o  <= 32'd0;
            ifid_pc4_o    <= 32'd0;
            ifid_valid_o  <= 1'b0;
            fetch_count_o <= 32'd0;
        end else if (flush_i) begin
            ifid_instr_o <= 32'd0;
            ifid_pc4_o   <= 32'd0;
            ifid_valid_o <= 1'b0;
        end else if (!stall_i) begin
            ifid_instr_o  <= imem_data_i;
            ifid_pc4_o    <= pc_plus4_o;
            ifid_valid_o  <= 1'b1;
            fetch_count_o <= fetch_count_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_etapa_fetch.sv
// Bench for etapa_fetch: directed scenarios plus randomized control traffic,
// each edge compared against an abstract next-PC / IF/ID model.
module tb_etapa_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [25:0] jump_index_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic [31:0] fetch_count_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    assign imem_data_i = imem_word(imem_addr_o);

    etapa_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_index_i    (jump_index_i),
        .imem_addr_o     (imem_addr_o),
        .imem_data_i     (imem_data_i),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_pc4_o      (ifid_pc4_o),
        .ifid_valid_o    (ifid_valid_o),
        .fetch_count_o   (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},    pc_o,                 m_pc);
        chk({tag, ".addr"},  imem_addr_o,          m_pc);
        chk({tag, ".pc4"},   pc_plus4_o,           m_pc + 32'd4);
        chk({tag, ".instr"}, ifid_instr_o,         m_instr);
        chk({tag, ".ifpc4"}, ifid_pc4_o,           m_pc4);
        chk({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, m_valid});
        chk({tag, ".count"}, fetch_count_o,        m_count);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
    endtask

    task automatic idle();
        stall_i = 0; flush_i = 0; branch_taken_i = 0; jump_i = 0;
        branch_target_i = 32'h0; jump_index_i = 26'h0;
    endtask

    // One rising edge: model computes its next state from the inputs in force.
    task automatic tick(input string tag);
        logic [31:0] npc, ninstr, npc4, ncnt;
        logic        nvalid;
        ninstr = m_instr; npc4 = m_pc4; nvalid = m_valid; ncnt = m_count;
        if (branch_taken_i)  npc = branch_target_i & ~32'd3;
        else if (jump_i)     npc = (m_pc4 & 32'hF000_0000) | ({6'd0, jump_index_i} * 4);
        else if (stall_i)    npc = m_pc;
        else                 npc = m_pc + 32'd4;
        if (flush_i) begin
            ninstr = 0; npc4 = 0; nvalid = 0;
        end else if (!stall_i) begin
            ninstr = imem_word(m_pc); npc4 = m_pc + 32'd4; nvalid = 1; ncnt = m_count + 1;
        end
        @(posedge clk); #1;
        if (rst_n) begin
            m_pc = npc; m_instr = ninstr; m_pc4 = npc4; m_valid = nvalid; m_count = ncnt;
        end else begin
            model_reset();
        end
        chk_all(tag);
    endtask

    // Asynchronous reset applied and released between edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk_all("reset");
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #1 chk_all("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // sequential fetch
        repeat (3) tick("seq");
        chk("seq3.pc", pc_o, 32'd12);
        chk("seq3.instr", ifid_instr_o, 32'hA000_0008);
        chk("seq3.ifpc4", ifid_pc4_o, 32'd12);
        chk("seq3.count", fetch_count_o, 32'd3);

        // stall at pc=8
        do_reset();
        repeat (2) tick("pre_stall");
        chk("stall.start_pc", pc_o, 32'd8);
        stall_i = 1;
        repeat (2) tick("stall");
        chk("stall.pc_held", pc_o, 32'd8);
        chk("stall.count_held", fetch_count_o, 32'd2);
        stall_i = 0;
        tick("unstall");
        chk("unstall.instr", ifid_instr_o, 32'hA000_0008);

        // branch over stall with flush at pc=16
        tick("to16");
        chk("br.start_pc", pc_o, 32'd16);
        stall_i = 1; branch_taken_i = 1; branch_target_i = 32'h0000_0043; flush_i = 1;
        tick("br");
        chk("br.pc", pc_o, 32'h40);
        chk("br.valid", {31'd0, ifid_valid_o}, 32'd0);
        chk("br.count", fetch_count_o, 32'd4);
        idle();
        tick("br_tgt");
        chk("br_tgt.instr", ifid_instr_o, 32'hA000_0040);

        // jump using region of ifid_pc4
        branch_taken_i = 1; branch_target_i = 32'h1000_0004;
        tick("j_setup");
        idle();
        tick("j_setup2");
        chk("j.ifpc4", ifid_pc4_o, 32'h1000_0008);
        jump_i = 1; jump_index_i = 26'h000_0100;
        tick("jump");
        chk("jump.pc", pc_o, 32'h1000_0400);
        idle();

        // PC wrap
        branch_taken_i = 1; branch_target_i = 32'hFFFF_FFFE;
        tick("wrap_setup");
        idle();
        chk("wrap.pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap.pc4", pc_plus4_o, 32'h0);
        tick("wrap");
        chk("wrap.next_pc", pc_o, 32'h0);
        chk("wrap.ifpc4", ifid_pc4_o, 32'h0);
        chk("wrap.valid", {31'd0, ifid_valid_o}, 32'd1);

        // async reset mid-run at pc=0x40, count=5
        do_reset();
        repeat (4) tick("ar_seq");
        branch_taken_i = 1; branch_target_i = 32'h40;
        tick("ar_br");
        idle();
        chk("ar.pc", pc_o, 32'h40);
        chk("ar.count", fetch_count_o, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.pc_rst", pc_o, 32'h0);
        chk("ar.count_rst", fetch_count_o, 32'h0);
        chk("ar.valid_rst", {31'd0, ifid_valid_o}, 32'd0);
        chk("ar.instr_rst", ifid_instr_o, 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        tick("ar_resume");
        chk("ar.resume_pc", pc_o, 32'd4);
        chk("ar.resume_instr", ifid_instr_o, 32'hA000_0000);

        // randomized control traffic
        for (int i = 0; i < 400; i++) begin
            stall_i         = ($urandom_range(0, 3) == 0);
            flush_i         = ($urandom_range(0, 7) == 0);
            branch_taken_i  = ($urandom_range(0, 9) == 0);
            jump_i          = ($urandom_range(0, 9) == 0);
            branch_target_i = $urandom;
            jump_index_i    = 26'($urandom);
            if (i == 200) begin
                idle();
                do_reset();
            end
            tick("rand");
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
